// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_pkg : read-mode names, flag bundle, depth helper           |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
package sync_fifo_pkg;

   localparam string FT_TRUE  = "TRUE";
   localparam string FT_FALSE = "FALSE";

   typedef struct packed {
      logic full;
      logic afull;
      logic empty;
      logic aempty;
   } fifo_flags_t;

   function automatic int unsigned fifo_depth(input int unsigned asize);
      return 32'd1 << asize;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_if : write/read handshake, status and threshold bundle     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface sync_fifo_if #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 4
);
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             wfull;
   logic             awfull;
   logic             rempty;
   logic             arempty;
   logic [ASIZE:0]   count;
   logic [ASIZE:0]   afull_thresh;
   logic [ASIZE:0]   aempty_thresh;
   logic             err_clr;
   logic             overflow;
   logic             underflow;

   modport master (
      output winc, wdata, rinc, afull_thresh, aempty_thresh, err_clr,
      input  rdata, wfull, awfull, rempty, arempty, count, overflow, underflow
   );

   modport slave (
      input  winc, wdata, rinc, afull_thresh, aempty_thresh, err_clr,
      output rdata, wfull, awfull, rempty, arempty, count, overflow, underflow
   );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo_mem : DSIZE x DEPTH storage, fall-through or registered rd |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int    DSIZE       = 8,
   parameter int    ASIZE       = 4,
   parameter string FALLTHROUGH = "TRUE"
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   input  wire logic             we,
   input  wire logic [ASIZE-1:0] waddr,
   input  wire logic [DSIZE-1:0] wdata,
   input  wire logic             re,
   input  wire logic [ASIZE-1:0] raddr,
   output logic      [DSIZE-1:0] rdata
);
   localparam int unsigned DEPTH = fifo_depth(ASIZE);

   logic [DSIZE-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   generate
      if (FALLTHROUGH == FT_TRUE) begin : g_fallthrough
         logic w_unused_rd;
         assign w_unused_rd = re ^ rst_n;
         assign rdata       = mem_q[raddr];
      end else begin : g_registered
         logic [DSIZE-1:0] rdata_q;
         logic [DSIZE-1:0] rdata_d;

         // Only an accepted read moves the output; otherwise the last word holds.
         always_comb begin
            rdata_d = rdata_q;
            if (re) begin
               rdata_d = mem_q[raddr];
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rdata_q <= '0;
            end else begin
               rdata_q <= rdata_d;
            end
         end

         assign rdata = rdata_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo : single-clock FIFO, count, thresholds, sticky errors      |
// | optional: SYNC_FIFO_ERR_EN enables overflow/underflow     rev 1.0    |
// +----------------------------------------------------------------------+
module sync_fifo
   import sync_fifo_pkg::*;
#(
   parameter int    DSIZE       = 8,
   parameter int    ASIZE       = 4,
   parameter string FALLTHROUGH = "TRUE"
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   sync_fifo_if.slave bus
);
   localparam int unsigned    DEPTH     = fifo_depth(ASIZE);
   localparam logic [ASIZE:0] c_depth_w = (ASIZE+1)'(DEPTH);

   logic [ASIZE:0] wbin_q,  wbin_d;
   logic [ASIZE:0] rbin_q,  rbin_d;
   logic [ASIZE:0] count_q, count_d;
   fifo_flags_t    flags_q, flags_d;
   logic           overflow_q,  overflow_d;
   logic           underflow_q, underflow_d;
   logic           w_wacc;
   logic           w_racc;

   always_comb begin
      // When full, a simultaneous read frees the slot the write lands in.
      w_wacc = bus.winc & (~flags_q.full | bus.rinc);
      w_racc = bus.rinc & ~flags_q.empty;

      wbin_d  = wbin_q + {{ASIZE{1'b0}}, w_wacc};
      rbin_d  = rbin_q + {{ASIZE{1'b0}}, w_racc};
      count_d = count_q + {{ASIZE{1'b0}}, w_wacc} - {{ASIZE{1'b0}}, w_racc};

      flags_d.full   = (count_d == c_depth_w);
      flags_d.empty  = (count_d == '0);
      flags_d.afull  = (count_d >= bus.afull_thresh);
      flags_d.aempty = (count_d <= bus.aempty_thresh);

`ifdef SYNC_FIFO_ERR_EN
      overflow_d  = (bus.winc & flags_q.full & ~bus.rinc) | (overflow_q  & ~bus.err_clr);
      underflow_d = (bus.rinc & flags_q.empty)            | (underflow_q & ~bus.err_clr);
`else
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
`endif
   end

`ifndef SYNC_FIFO_ERR_EN
   logic w_unused_err;
   assign w_unused_err = bus.err_clr;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbin_q      <= '0;
         rbin_q      <= '0;
         count_q     <= '0;
         flags_q     <= '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wbin_q      <= wbin_d;
         rbin_q      <= rbin_d;
         count_q     <= count_d;
         flags_q     <= flags_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign bus.count     = count_q;
   assign bus.wfull     = flags_q.full;
   assign bus.awfull    = flags_q.afull;
   assign bus.rempty    = flags_q.empty;
   assign bus.arempty   = flags_q.aempty;
   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;

   sync_fifo_mem #(
      .DSIZE       (DSIZE),
      .ASIZE       (ASIZE),
      .FALLTHROUGH (FALLTHROUGH)
   ) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (w_wacc),
      .waddr (wbin_q[ASIZE-1:0]),
      .wdata (bus.wdata),
      .re    (w_racc),
      .raddr (rbin_q[ASIZE-1:0]),
      .rdata (bus.rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_sync_fifo : fall-through and registered FIFOs against a queue     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_sync_fifo;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_if #(.DSIZE(8), .ASIZE(2)) ift ();
   sync_fifo_if #(.DSIZE(8), .ASIZE(2)) ifr ();

   sync_fifo #(.DSIZE(8), .ASIZE(2), .FALLTHROUGH("TRUE")) u_ft (
      .clk(clk), .rst_n(rst_n), .bus(ift)
   );
   sync_fifo #(.DSIZE(8), .ASIZE(2), .FALLTHROUGH("FALSE")) u_reg (
      .clk(clk), .rst_n(rst_n), .bus(ifr)
   );

   int unsigned tests = 0;
   int unsigned fails = 0;

   // Reference: contents as a queue, flags derived from its size.
   logic [7:0] q[$];
   logic [7:0] exp_rreg;
   logic       exp_ovf, exp_unf, exp_aw, exp_ae;
   logic [2:0] af_th, ae_th;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [7:0] d, input logic r, input logic ec);
      ift.winc = w;  ift.wdata = d;  ift.rinc = r;  ift.err_clr = ec;
      ifr.winc = w;  ifr.wdata = d;  ifr.rinc = r;  ifr.err_clr = ec;
      ift.afull_thresh = af_th;  ift.aempty_thresh = ae_th;
      ifr.afull_thresh = af_th;  ifr.aempty_thresh = ae_th;
   endtask

   task automatic model_reset();
      q.delete();
      exp_rreg = 8'h00;
      exp_ovf  = 1'b0;
      exp_unf  = 1'b0;
      exp_aw   = 1'b0;
      exp_ae   = 1'b1;
   endtask

   task automatic check_all();
      int n;
      n = q.size();
      chk("ft.count",    32'(ift.count),     32'(n));
      chk("ft.wfull",    32'(ift.wfull),     32'(n == 4));
      chk("ft.rempty",   32'(ift.rempty),    32'(n == 0));
      chk("ft.awfull",   32'(ift.awfull),    32'(exp_aw));
      chk("ft.arempty",  32'(ift.arempty),   32'(exp_ae));
      chk("ft.overflow", 32'(ift.overflow),  32'(exp_ovf));
      chk("ft.underflow",32'(ift.underflow), 32'(exp_unf));
      if (n != 0) chk("ft.rdata", 32'(ift.rdata), 32'(q[0]));
      chk("reg.count",    32'(ifr.count),     32'(n));
      chk("reg.wfull",    32'(ifr.wfull),     32'(n == 4));
      chk("reg.rempty",   32'(ifr.rempty),    32'(n == 0));
      chk("reg.awfull",   32'(ifr.awfull),    32'(exp_aw));
      chk("reg.arempty",  32'(ifr.arempty),   32'(exp_ae));
      chk("reg.overflow", 32'(ifr.overflow),  32'(exp_ovf));
      chk("reg.underflow",32'(ifr.underflow), 32'(exp_unf));
      chk("reg.rdata",    32'(ifr.rdata),     32'(exp_rreg));
   endtask

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic ec);
      logic full, empty, wacc, racc;
      drive(w, d, r, ec);
      full  = (q.size() == 4);
      empty = (q.size() == 0);
      wacc  = w && (!full || r);
      racc  = r && !empty;
      @(posedge clk);
      if (racc) exp_rreg = q.pop_front();
      if (wacc) q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
      exp_ovf = (w && full && !r) || (exp_ovf && !ec);
      exp_unf = (r && empty)      || (exp_unf && !ec);
`endif
      exp_aw = (q.size() >= int'(af_th));
      exp_ae = (q.size() <= int'(ae_th));
      #1;
      check_all();
   endtask

   initial begin
      af_th = 3'd3;
      ae_th = 3'd1;
      drive(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("fill.awfull3", 32'(ift.awfull), 32'd1);
      step(1'b1, 8'h44, 1'b0, 1'b0);
      chk("fill.count4", 32'(ift.count), 32'd4);
      chk("fill.wfull",  32'(ift.wfull), 32'd1);
      chk("fill.head",   32'(ift.rdata), 32'h11);

      // Write while full is dropped
      step(1'b1, 8'h55, 1'b0, 1'b0);
      chk("ovf.count4", 32'(ift.count), 32'd4);
`ifdef SYNC_FIFO_ERR_EN
      chk("ovf.flag", 32'(ift.overflow), 32'd1);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Drain
      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drain.rempty", 32'(ift.rempty), 32'd1);

      // Simultaneous read/write at count 2, then at full
      repeat (2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      repeat (10) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("simul2.count", 32'(ift.count), 32'd2);
      repeat (2) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      repeat (10) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      chk("simul4.count", 32'(ift.count), 32'd4);
      chk("simul4.wfull", 32'(ift.wfull), 32'd1);
      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Registered read and read while empty
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("reg.a5", 32'(ifr.rdata), 32'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("reg.hold", 32'(ifr.rdata), 32'hA5);
`ifdef SYNC_FIFO_ERR_EN
      chk("unf.flag", 32'(ifr.underflow), 32'd1);
`endif
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset mid-stream at count 3
      repeat (3) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("arst.count", 32'(ift.count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b0);
      chk("arst.fresh", 32'(ift.rdata), 32'h77);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Randomized traffic with moving thresholds
      for (int i = 0; i < 400; i++) begin
         af_th = 3'($urandom_range(0, 5));
         ae_th = 3'($urandom_range(0, 5));
         step(1'($urandom), 8'($urandom), 1'($urandom), 1'(($urandom % 16) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
